// File: rtl/nios_core_pio_led_ctrl.sv
// nios_core_pio_led_ctrl
// Avalon-MM LED/GPIO output controller. It provides:
//   - a DATA register
//   - atomic set (OUTSET) and clear (OUTCLR) write ports
//   - a per-channel blink engine, paced by a programmable prescaler
// Optional feature macro: PIO_LED_PWM_EN. When it is defined, the block adds
// an 8-bit DUTY register at address 6 and a free-running PWM counter that
// gates out_port.
module nios_core_pio_led_ctrl #(
    parameter int unsigned                DATA_WIDTH     = 4,
    parameter logic [DATA_WIDTH-1:0]      RESET_VALUE    = '0,
    parameter int unsigned                PRESCALE_WIDTH = 24,
    parameter logic [PRESCALE_WIDTH-1:0]  DEFAULT_PERIOD = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_BLINK  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
    localparam logic [2:0] ADDR_DUTY   = 3'd6;

    logic                      wr_en;
    logic [DATA_WIDTH-1:0]     wd_data;
    logic [PRESCALE_WIDTH-1:0] wd_period;
    logic                      unused_wd;

    logic [DATA_WIDTH-1:0]     data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0]     blink_mask_q, blink_mask_d;
    logic [PRESCALE_WIDTH-1:0] period_q, period_d;
    logic [PRESCALE_WIDTH-1:0] count_q, count_d;
    logic                      phase_q, phase_d;
    logic [DATA_WIDTH-1:0]     out_port_q, out_port_d;
    logic [DATA_WIDTH-1:0]     gated_value;

`ifdef PIO_LED_PWM_EN
    logic [7:0]                duty_q, duty_d;
    logic [7:0]                pwm_cnt_q, pwm_cnt_d;
`endif

    assign wr_en     = chipselect & ~write_n;
    assign wd_data   = writedata[DATA_WIDTH-1:0];
    assign wd_period = writedata[PRESCALE_WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Register-file updates: DATA/BLINK/PERIOD writes and atomic set/clear
    always_comb begin
        data_out_d   = data_out_q;
        blink_mask_d = blink_mask_q;
        period_d     = period_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_out_d   = wd_data;
                ADDR_BLINK:  blink_mask_d = wd_data;
                ADDR_PERIOD: period_d     = wd_period;
                ADDR_OUTSET: data_out_d   = data_out_q | wd_data;
                ADDR_OUTCLR: data_out_d   = data_out_q & ~wd_data;
                default:     data_out_d   = data_out_q;
            endcase
        end
    end

    // Prescaler and blink phase; a PERIOD write restarts the count and beats a terminal count
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (wr_en && address == ADDR_PERIOD) begin
            count_d = wd_period;
            phase_d = 1'b0;
        end else if (period_q == '0) begin
            count_d = '0;
            phase_d = 1'b0;
        end else if (count_q == '0) begin
            count_d = period_q;
            phase_d = ~phase_q;
        end else begin
            count_d = count_q - PRESCALE_WIDTH'(1);
        end
    end

    // LED drive: blinking channels are gated off during the high phase, optionally PWM-dimmed
    always_comb begin
        gated_value = data_out_q & ~(blink_mask_q & {DATA_WIDTH{phase_q}});
`ifdef PIO_LED_PWM_EN
        duty_d    = duty_q;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        if (wr_en && address == ADDR_DUTY) begin
            duty_d = writedata[7:0];
        end
        out_port_d = gated_value & {DATA_WIDTH{(pwm_cnt_q < duty_q)}};
`else
        out_port_d = gated_value;
`endif
    end

    // State registers, all returned to their reset values asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q   <= RESET_VALUE;
            blink_mask_q <= '0;
            period_q     <= DEFAULT_PERIOD;
            count_q      <= DEFAULT_PERIOD;
            phase_q      <= 1'b0;
            out_port_q   <= RESET_VALUE;
`ifdef PIO_LED_PWM_EN
            duty_q       <= 8'hFF;
            pwm_cnt_q    <= 8'd0;
`endif
        end else begin
            data_out_q   <= data_out_d;
            blink_mask_q <= blink_mask_d;
            period_q     <= period_d;
            count_q      <= count_d;
            phase_q      <= phase_d;
            out_port_q   <= out_port_d;
`ifdef PIO_LED_PWM_EN
            duty_q       <= duty_d;
            pwm_cnt_q    <= pwm_cnt_d;
`endif
        end
    end

    // Zero-latency read mux; write-only and unused addresses read as zero
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[DATA_WIDTH-1:0]     = data_out_q;
            ADDR_BLINK:  readdata[DATA_WIDTH-1:0]     = blink_mask_q;
            ADDR_PERIOD: readdata[PRESCALE_WIDTH-1:0] = period_q;
            ADDR_STATUS: readdata[0]                  = phase_q;
`ifdef PIO_LED_PWM_EN
            ADDR_DUTY:   readdata[7:0]                = duty_q;
`endif
            default:     readdata = '0;
        endcase
    end

    assign out_port = out_port_q;

endmodule
